// File: rtl/t03_pad_poll_ctrl.sv
// NES-style pad poller: latch pulse, settle, then 8 sample/clock steps feeding a serial-to-parallel register.
// Start latency 1 cycle; frame is 17*CLK_DIV+9 cycles; no backpressure, start_req is dropped while busy.
module t03_pad_poll_ctrl #(
  parameter int CLK_DIV     = 300,
  parameter int POLL_PERIOD = 833333
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable_i,
  input  logic start_req_i,
  input  logic pad_data_i,
  output logic pad_latch_o,
  output logic pad_clk_o,
  output logic shift_en_o,
  output logic shift_data_o,
  output logic finished_o,
  output logic busy_o
);

  localparam int PH_W = $clog2(2 * CLK_DIV);
  localparam int PL_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam logic [PH_W-1:0] LATCH_END = PH_W'(2 * CLK_DIV - 1);
  localparam logic [PH_W-1:0] DIV_END   = PH_W'(CLK_DIV - 1);
  localparam logic [PL_W-1:0] POLL_END  = PL_W'(POLL_PERIOD - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_SETTLE, S_SAMPLE, S_CLK_HI, S_CLK_LO, S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [PH_W-1:0] phase_q, phase_d;
  logic [2:0]      bit_q, bit_d;
  logic [PL_W-1:0] poll_q, poll_d;
  logic            sync1_q, sync2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      bit_q   <= '0;
      poll_q  <= '0;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      poll_q  <= poll_d;
      sync1_q <= pad_data_i;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    bit_d       = bit_q;
    poll_d      = poll_q;
    pad_latch_o = 1'b0;
    pad_clk_o   = 1'b0;
    shift_en_o  = 1'b0;
    finished_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable_i) poll_d = poll_q + 1'b1;
        if (start_req_i || (enable_i && poll_q == POLL_END)) begin
          state_d = S_LATCH;
          poll_d  = '0;
          bit_d   = '0;
          phase_d = '0;
        end
      end
      S_LATCH: begin
        pad_latch_o = 1'b1;
        if (phase_q == LATCH_END) begin
          state_d = S_SETTLE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      // Settle covers pad output delay plus the two synchronizer stages.
      S_SETTLE: begin
        if (phase_q == DIV_END) begin
          state_d = S_SAMPLE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_SAMPLE: begin
        shift_en_o = 1'b1;
        phase_d    = '0;
        if (bit_q == 3'd7) begin
          state_d = S_DONE;
        end else begin
          bit_d   = bit_q + 1'b1;
          state_d = S_CLK_HI;
        end
      end
      S_CLK_HI: begin
        pad_clk_o = 1'b1;
        if (phase_q == DIV_END) begin
          state_d = S_CLK_LO;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_CLK_LO: begin
        if (phase_q == DIV_END) begin
          state_d = S_SAMPLE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_DONE: begin
        finished_o = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o       = (state_q != S_IDLE);
  assign shift_data_o = sync2_q;

endmodule

// File: doc/t03_pad_poll_ctrl.md
# t03_pad_poll_ctrl

Sequencer for the team's 8-bit serial-to-parallel button register. The block periodically polls an external NES-style serial game pad. It pulses the pad's latch line, then clocks out eight button bits. For each bit it drives the shift register's shift-enable (`button_en`) and data inputs, and at the end of the frame it issues the `finished` strobe that transfers the shifted byte into the latched output. It sits between the pad pins and the shift register in the input front end.

## Interface
Parameters:
- `CLK_DIV`, default 300: half-period of the pad clock, and the settle time, in `clk` cycles. Minimum 3.
- `POLL_PERIOD`, default 833333: `clk` cycles spent in IDLE between automatic polls. Minimum 1.

Ports:
- `clk`  in  1: system clock. Everything is on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `enable`  in  1: allows automatic periodic polling.
- `start_req`  in  1: requests an immediate poll. Honoured only in IDLE.
- `pad_data`  in  1: serial data from the pad. Asynchronous, active-low buttons.
- `pad_latch`  out  1: latch pulse to the pad.
- `pad_clk`  out  1: shift clock to the pad. Idles low.
- `shift_en`  out  1: one-cycle shift strobe. Drives the shift register's `button_en`.
- `shift_data`  out  1: synchronized pad bit. Drives the shift register's `data`.
- `finished`  out  1: one-cycle frame-complete strobe. Drives the shift register's `finished`.
- `busy`  out  1: high whenever the state is not IDLE.

## Operation
- Input synchronizer:
  - `pad_data` passes through a 2-flop synchronizer. Both flops reset to 1 (line released, no button pressed).
  - `shift_data` is the second synchronizer flop.
- States: IDLE, LATCH, SETTLE, SAMPLE, CLK_HI, CLK_LO, DONE.
- Counters:
  - Phase counter: width `$clog2(2*CLK_DIV)`.
  - Bit counter: 3 bits.
  - Poll counter: width `$clog2(POLL_PERIOD)`, minimum 1 bit.
- IDLE:
  - The poll counter increments each cycle while `enable`=1. It holds while `enable`=0.
  - Go to LATCH when `start_req`=1, or when `enable`=1 and the poll counter equals `POLL_PERIOD`-1.
  - On that transition, clear the poll counter, the bit counter and the phase counter.
- LATCH: `pad_latch`=1 for 2·`CLK_DIV` cycles, then go to SETTLE.
- SETTLE: all pad outputs low for `CLK_DIV` cycles, then go to SAMPLE. This wait covers pad output delay plus the synchronizer.
- SAMPLE:
  - One cycle with `shift_en`=1.
  - If the bit counter is 7, go to DONE. Otherwise increment the bit counter and go to CLK_HI.
- CLK_HI: `pad_clk`=1 for `CLK_DIV` cycles, then go to CLK_LO.
- CLK_LO: `pad_clk`=0 for `CLK_DIV` cycles, then go to SAMPLE.
- DONE: one cycle with `finished`=1, then go to IDLE.
- Bit order:
  - The shift register shifts in at bit 0, so the first pad bit (A) ends in bit 7 and the last bit (Right) ends in bit 0.
  - No inversion is applied. Active-low pad data matches the shift register's all-ones reset value (no buttons pressed).
- Outputs are Moore, decoded from registered state. They do not depend combinationally on any input.

## Timing
- Reset values: state IDLE, all counters 0, synchronizer flops 1. `pad_latch`, `pad_clk`, `shift_en`, `finished` and `busy` are 0. `shift_data` is 1.
- Start latency: the trigger is sampled in IDLE at cycle t. LATCH, `pad_latch`=1 and `busy`=1 all begin at t+1.
- Frame length, from LATCH entry through DONE inclusive, is 17·`CLK_DIV`+9 cycles (77 cycles at `CLK_DIV`=4). The breakdown is:
  - 2D latch
  - D settle
  - 8 samples
  - 7 clock pulses of 2D each
  - 1 done
- Each `shift_en` cycle uses `shift_data` sampled that same cycle. The shift register captures it on the next rising edge.
- `finished` rises one cycle after the eighth `shift_en`, so the shift register already holds all 8 bits.
- Boundary conditions:
  - `start_req` while `busy`=1: ignored, not queued.
  - `enable` dropped mid-frame: the frame completes. The poll counter holds in IDLE until `enable` returns.
  - `start_req` and poll expiry together: a single frame starts.
  - `rst` mid-frame: next cycle the block is in IDLE with all outputs at reset values. No `finished` is issued.
  - `POLL_PERIOD`=1 with `enable` held high: back-to-back frames, one IDLE cycle between DONE and LATCH.

## Test plan
All scenarios use `CLK_DIV`=4, `POLL_PERIOD`=200, with the real shift register attached.
- Reset then idle, `enable`=0, no `start_req` for 500 cycles -> all outputs at reset values and `busy`=0 throughout.
- `start_req` pulse, pad model returning serial 0,1,1,1,1,1,1,0 (A and Right pressed) -> all of:
  - `pad_latch` high for exactly 8 cycles.
  - 8 `shift_en` pulses and 7 `pad_clk` pulses of 4 cycles each.
  - `finished` in frame cycle 77.
  - Latched value equals 8'h7E.
- `enable`=1 held with a constant-1 pad -> frames start exactly 200 IDLE cycles apart and the latched value stays 8'hFF.
- `start_req` asserted in cycles 10–30 of a frame -> no second frame; `busy` falls once after DONE.
- `rst` asserted during CLK_HI of bit 3 -> outputs reset next cycle, no `finished` pulse, latched value unchanged from before the frame.
- `enable` dropped mid-frame -> frame completes with `finished`, then no further automatic polls.
